dcache_controller: RTL

- Direct-mapped, write-back, write-allocate data cache that responds to the pipeline's MEM-stage load/store requests.
- On the CPU side it is the responder: it returns load data, absorbs stores, and stalls the pipeline on a miss.
- On the memory side it is the initiator: it issues whole-line writebacks and refills to the slow off-chip data memory over a level req/ack handshake.
- Sits between EXMEM/MEMWB and the external data memory, replacing the direct single-cycle data memory hookup.

---
 rtl/dcache_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// slow line-wide data memory driven over a level req / single-cycle ack handshake.
module dcache_controller #(
    parameter int NUM_LINES = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p1_req_i,
    input  logic          p1_write_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_data_i,
    output logic [31:0]   p1_data_o,
    output logic          p1_stall_o,
    output logic          mem_enable_o,
    output logic          mem_write_o,
    output logic [31:0]   mem_addr_o,
    output logic [255:0]  mem_data_o,
    input  logic [255:0]  mem_data_i,
    input  logic          mem_ack_i
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 32 - 5 - INDEX_W;
    localparam int LINE_W  = 256;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WRITEBACK   = 2'd1,
        S_ALLOCATE    = 2'd2,
        S_REFILL_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [2:0]           word_s;
    logic [INDEX_W-1:0]   index_s;
    logic [TAG_W-1:0]     tag_s;
    logic                 hit_s;
    logic [LINE_W-1:0]    cur_line_s;
    logic [LINE_W-1:0]    line_wdata_s;
    logic                 line_we_s;
    logic                 tag_we_s;
    logic                 unused_s;

    assign word_s     = p1_addr_i[4:2];
    assign index_s    = p1_addr_i[4+INDEX_W:5];
    assign tag_s      = p1_addr_i[31:5+INDEX_W];
    assign cur_line_s = data_q[index_s];
    assign hit_s      = p1_req_i & valid_q[index_s] & (tag_q[index_s] == tag_s);
    assign unused_s   = ^p1_addr_i[1:0];

    // Next-state, array write controls and all outputs; reset forces every output idle
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we_s    = 1'b0;
        tag_we_s     = 1'b0;
        line_wdata_s = cur_line_s;
        p1_data_o    = 32'h0;
        p1_stall_o   = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = {LINE_W{1'b0}};
        if (rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (hit_s) begin
                        if (p1_write_i) begin
                            line_we_s = 1'b1;
                            line_wdata_s[{word_s, 5'b00000} +: 32] = p1_data_i;
                            dirty_d[index_s] = 1'b1;
                        end else begin
                            p1_data_o = cur_line_s[{word_s, 5'b00000} +: 32];
                        end
                    end else if (p1_req_i) begin
                        p1_stall_o = 1'b1;
                        if (valid_q[index_s] && dirty_q[index_s]) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_ALLOCATE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WRITEBACK: begin
                    p1_stall_o   = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {tag_q[index_s], index_s, 5'b00000};
                    mem_data_o   = cur_line_s;
                    if (mem_ack_i) begin
                        state_d = S_ALLOCATE;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
                S_ALLOCATE: begin
                    p1_stall_o   = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {tag_s, index_s, 5'b00000};
                    if (mem_ack_i) begin
                        line_we_s        = 1'b1;
                        tag_we_s         = 1'b1;
                        line_wdata_s     = mem_data_i;
                        valid_d[index_s] = 1'b1;
                        dirty_d[index_s] = 1'b0;
                        state_d          = S_REFILL_DONE;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
                S_REFILL_DONE: begin
                    p1_stall_o = 1'b1;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = S_IDLE;
        end
    end

    // Controller state and per-line valid/dirty bits
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= {NUM_LINES{1'b0}};
            dirty_q <= {NUM_LINES{1'b0}};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_i) begin
        if (line_we_s) begin
            data_q[index_s] <= line_wdata_s;
        end
        if (tag_we_s) begin
            tag_q[index_s] <= tag_s;
        end
    end
endmodule
